// File: rtl/lupa_cfg_sequencer_if.sv
// Host-side and shifter-side signal bundle for the LUPA300 configuration sequencer.
// The master modport is the host/shifter environment; the slave modport is the sequencer.
interface lupa_cfg_sequencer_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;
    logic        start_all;
    logic        start_dirty;
    logic        word_valid;
    logic [3:0]  word_addr;
    logic [11:0] word_data;
    logic        word_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  words_sent;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, start_all, start_dirty, word_ack,
        input  rd_data, word_valid, word_addr, word_data, busy, done, err, words_sent
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, start_all, start_dirty, word_ack,
        output rd_data, word_valid, word_addr, word_data, busy, done, err, words_sent
    );
endinterface

// File: rtl/lupa_cfg_sequencer.sv
// Shadow register file (16 x 12-bit) for the LUPA300 SPI configuration space, with
// dirty tracking and a one-word-at-a-time upload over a valid/ack handshake.
module lupa_cfg_sequencer #(
    parameter int unsigned  ACK_TIMEOUT = 1024,
    // Reset values, index 0 in the least significant 12 bits.
    parameter logic [191:0] DEF_TABLE   = {12'h0db, 12'h6db, 12'hadf, 12'hfb0,
                                           12'h0f0, 12'h055, 12'h06b, 12'h04a,
                                           12'h1e1, 12'h000, 12'h000, 12'h002,
                                           12'h0a0, 12'h000, 12'h000, 12'h028}
) (
    input  logic                  clock_20,
    input  logic                  rst_n,
    lupa_cfg_sequencer_if.slave   bus
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ISSUE, S_FINISH} state_t;

    state_t      state_q, state_d;
    logic [11:0] shadow_q [16];
    logic [11:0] shadow_d [16];
    logic [15:0] dirty_q, dirty_d;
    logic [15:0] sel_q, sel_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        word_valid_q, word_valid_d;
    logic [3:0]  word_addr_q, word_addr_d;
    logic [11:0] word_data_q, word_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [4:0]  words_sent_q, words_sent_d;
    logic [11:0] rd_data_q, rd_data_d;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        dirty_d      = dirty_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        tmo_d        = tmo_q;
        word_valid_d = word_valid_q;
        word_addr_d  = word_addr_q;
        word_data_d  = word_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        words_sent_d = words_sent_q;
        rd_data_d    = shadow_q[bus.rd_addr];

        case (state_q)
            S_IDLE: begin
                if (bus.start_all || bus.start_dirty) begin
                    sel_d        = bus.start_all ? 16'hFFFF : dirty_q;
                    ptr_d        = 4'd0;
                    words_sent_d = 5'd0;
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (sel_q[ptr_q]) begin
                    word_addr_d  = ptr_q;
                    word_data_d  = shadow_q[ptr_q];
                    word_valid_d = 1'b1;
                    tmo_d        = '0;
                    state_d      = S_ISSUE;
                end else if (ptr_q == 4'hF) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
            S_ISSUE: begin
                if (bus.word_ack) begin
                    word_valid_d   = 1'b0;
                    words_sent_d   = words_sent_q + 5'd1;
                    dirty_d[ptr_q] = 1'b0;
                    if (ptr_q == 4'hF) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        ptr_d   = ptr_q + 4'd1;
                        state_d = S_SCAN;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Shifter never answered: abandon the pass, keep dirty bits for a retry.
                    word_valid_d = 1'b0;
                    err_d        = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Applied last so a host write in the ack cycle keeps the entry dirty.
        if (bus.wr_en) begin
            shadow_d[bus.wr_addr] = bus.wr_data;
            dirty_d[bus.wr_addr]  = 1'b1;
        end
    end

    always_ff @(posedge clock_20 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < 16; i++) shadow_q[i] <= DEF_TABLE[i*12 +: 12];
            dirty_q      <= 16'hFFFF;
            sel_q        <= 16'h0000;
            ptr_q        <= 4'd0;
            tmo_q        <= '0;
            word_valid_q <= 1'b0;
            word_addr_q  <= 4'd0;
            word_data_q  <= 12'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            words_sent_q <= 5'd0;
            rd_data_q    <= 12'd0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            dirty_q      <= dirty_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            tmo_q        <= tmo_d;
            word_valid_q <= word_valid_d;
            word_addr_q  <= word_addr_d;
            word_data_q  <= word_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            words_sent_q <= words_sent_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_addr  = word_addr_q;
    assign bus.word_data  = word_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.words_sent = words_sent_q;

endmodule

// File: tb/tb_lupa_cfg_sequencer.sv
// Bench for lupa_cfg_sequencer: register readback table, scoreboarded uploads,
// write-in-ack, ack timeout, start collisions and mid-upload reset.
module tb_lupa_cfg_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #25 clk = ~clk;

    lupa_cfg_sequencer_if bus();

    lupa_cfg_sequencer #(.ACK_TIMEOUT(16)) dut (
        .clock_20 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [3:0]  addr;
        bit          wr;
        logic [11:0] wdata;
        logic [11:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [11:0] data;
    } word_t;

    localparam logic [11:0] DEFS [16] = '{12'h028, 12'h000, 12'h000, 12'h0a0,
                                          12'h002, 12'h000, 12'h000, 12'h1e1,
                                          12'h04a, 12'h06b, 12'h055, 12'h0f0,
                                          12'hfb0, 12'hadf, 12'h6db, 12'h0db};

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          ack_delay = 3;
    bit          ack_en = 1'b1;
    word_t       exp_q [$];
    logic [11:0] model [16];
    logic [15:0] mdirty;
    vec_t        vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Shifter model: ack each word ack_delay cycles after it is presented.
    initial begin
        int cnt;
        cnt = 0;
        bus.word_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.word_ack = 1'b0;
            if (ack_en && bus.word_valid && rst_n) begin
                if (cnt == ack_delay - 1) begin
                    bus.word_ack = 1'b1;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (rst_n && bus.word_valid && bus.word_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%0h:%0h expected=none", bus.word_addr, bus.word_data);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                chk("word_addr", 32'(bus.word_addr), 32'(w.addr));
                chk("word_data", 32'(bus.word_data), 32'(w.data));
            end
        end
    end

    task automatic push_upload(input bit all, output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (all || mdirty[i]) begin
                word_t w;
                w.addr = 4'(i);
                w.data = model[i];
                exp_q.push_back(w);
                n++;
            end
        end
        mdirty = 16'h0000;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [11:0] d);
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        model[a] = d;
        mdirty[a] = 1'b1;
    endtask

    task automatic pulse_start(input bit all, input bit dirty);
        @(posedge clk); #1;
        bus.start_all = all; bus.start_dirty = dirty;
        @(posedge clk); #1;
        bus.start_all = 1'b0; bus.start_dirty = 1'b0;
    endtask

    task automatic wait_end(input string name, input int max);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && !bus.err && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL %s_end actual=timeout expected=done_or_err", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk); #1;
        if (v.wr) begin
            bus.wr_en = 1'b1; bus.wr_addr = v.addr; bus.wr_data = v.wdata;
            model[v.addr] = v.wdata;
            mdirty[v.addr] = 1'b1;
        end
        bus.rd_addr = v.addr;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        @(posedge clk); #1;
        chk("rd_data", 32'(bus.rd_data), 32'(v.exp_rd));
    endtask

    task automatic run_upload(input string name, input bit all, input bit dirty, input int exp_words);
        int n;
        int d0;
        push_upload(all, n);
        chk({name, "_expected_count"}, 32'(n), 32'(exp_words));
        d0 = done_cnt;
        pulse_start(all, dirty);
        chk({name, "_busy"}, 32'(bus.busy), 32'd1);
        wait_end(name, 200);
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_words_sent"}, 32'(bus.words_sent), 32'(exp_words));
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int d0;
        bit found;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        bus.start_all = 1'b0; bus.start_dirty = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model[i] = DEFS[i];
            vecs[i] = '{addr: 4'(i), wr: 1'b0, wdata: 12'h000, exp_rd: DEFS[i]};
        end
        mdirty = 16'hFFFF;
        vecs[16] = '{addr: 4'd2,  wr: 1'b1, wdata: 12'h5a5, exp_rd: 12'h5a5};
        vecs[17] = '{addr: 4'd15, wr: 1'b1, wdata: 12'hfff, exp_rd: 12'hfff};
        vecs[18] = '{addr: 4'd0,  wr: 1'b1, wdata: 12'h001, exp_rd: 12'h001};
        vecs[19] = '{addr: 4'd2,  wr: 1'b0, wdata: 12'h000, exp_rd: 12'h5a5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word_addr",  32'(bus.word_addr),  32'd0);
        chk("rst_word_data",  32'(bus.word_data),  32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_err",        32'(bus.err),        32'd0);
        chk("rst_words_sent", 32'(bus.words_sent), 32'd0);
        chk("rst_rd_data",    32'(bus.rd_data),    32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) apply_vec(vecs[i]);

        // 1: full dirty upload of defaults, then an empty pass
        run_upload("t1", 1'b0, 1'b1, 16);
        run_upload("empty", 1'b0, 1'b1, 0);

        // 2: two changed registers only
        host_write(4'd7, 12'h123);
        host_write(4'd12, 12'hff0);
        run_upload("t2", 1'b0, 1'b1, 2);

        // 3: write idx3 in the cycle its word is acked
        push_upload(1'b1, n);
        d0 = done_cnt;
        pulse_start(1'b1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (bus.word_valid && bus.word_ack && bus.word_addr == 4'd3) found = 1'b1;
        end
        chk("t3_idx3_ack_seen", 32'(found), 32'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 12'habc;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        model[3] = 12'habc;
        mdirty[3] = 1'b1;
        wait_end("t3", 200);
        chk("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t3_words_sent", 32'(bus.words_sent), 32'd16);
        run_upload("t3b", 1'b0, 1'b1, 1);

        // 4: ack timeout
        host_write(4'd5, 12'h3c3);
        ack_en = 1'b0;
        d0 = done_cnt;
        pulse_start(1'b0, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (bus.word_valid) found = 1'b1;
        end
        chk("t4_valid_rose", 32'(found), 32'd1);
        chk("t4_word_addr", 32'(bus.word_addr), 32'd5);
        n = 0;
        while (bus.word_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_valid_cycles", 32'(n), 32'd16);
        chk("t4_err", 32'(bus.err), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        ack_en = 1'b1;
        run_upload("t4b", 1'b0, 1'b1, 1);
        chk("t4_err_cleared", 32'(bus.err), 32'd0);

        // 5: simultaneous starts, start while busy ignored
        push_upload(1'b1, n);
        d0 = done_cnt;
        pulse_start(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        pulse_start(1'b0, 1'b1);
        wait_end("t5", 200);
        repeat (40) @(negedge clk);
        chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t5_words_sent", 32'(bus.words_sent), 32'd16);
        chk("t5_queue_left", 32'(exp_q.size()), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();

        // 6: reset in the middle of an issued word
        host_write(4'd13, 12'h111);
        ack_en = 1'b0;
        pulse_start(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_valid_before", 32'(bus.word_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", 32'(bus.word_valid), 32'd0);
        chk("t6_busy_async", 32'(bus.busy), 32'd0);
        bus.rd_addr = 4'd13;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = DEFS[i];
        mdirty = 16'hFFFF;
        exp_q.delete();
        ack_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_rd13", 32'(bus.rd_data), 32'h0adf);
        run_upload("t6b", 1'b0, 1'b1, 16);

        for (int i = 16; i < 20; i++) apply_vec(vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
